// File: rtl/port_io_sched_if.sv
// Bundle of the execute-path request signals and the four neighbour ports
// around port_io_sched. The slave modport is the scheduler's view. The
// master modport is the surrounding node's view (execute path plus
// neighbours).
interface port_io_sched_if #(
  parameter int DATA_W = 8
);
  // Execute-path read side
  logic                  rd_req;
  logic [2:0]            rd_sel;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_done;

  // Execute-path write side
  logic                  wr_req;
  logic [2:0]            wr_sel;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_done;
  logic                  stall;

  // Neighbour ports: port i occupies in_data[i*DATA_W +: DATA_W]
  logic [4*DATA_W-1:0]   in_data;
  logic [3:0]            in_valid;
  logic [3:0]            in_ready;
  logic [DATA_W-1:0]     out_data;
  logic [3:0]            out_valid;
  logic [3:0]            out_ack;

  // Last ANY transfer: bit2 = valid, bits1:0 = port index
  logic [2:0]            last_port;

  modport slave (
    input  rd_req, rd_sel, wr_req, wr_sel, wr_data, in_data, in_valid, out_ack,
    output rd_data, rd_done, wr_done, stall, in_ready, out_data, out_valid, last_port
  );

  modport master (
    output rd_req, rd_sel, wr_req, wr_sel, wr_data, in_data, in_valid, out_ack,
    input  rd_data, rd_done, wr_done, stall, in_ready, out_data, out_valid, last_port
  );
endinterface

// File: rtl/port_io_sched.sv
// port_io_sched: sequences blocking reads and writes between the execute path
// and the four neighbour ports. It resolves the ANY, LAST and NIL
// pseudo-ports, and it holds stall high while a transfer waits for its
// partner.
// Optional macro PORT_ANY_RR_EN: when defined, ANY arbitration is round-robin.
// The search starts after the previous ANY winner. When it is undefined, the
// lowest index wins.
module port_io_sched #(
  parameter int DATA_W = 8,
  parameter int NPORT  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  port_io_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_e;

  localparam logic [2:0] SEL_ANY  = 3'd4;
  localparam logic [2:0] SEL_LAST = 3'd5;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [NPORT-1:0]  in_ready_q, in_ready_d;
  logic [NPORT-1:0]  out_valid_q, out_valid_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic [2:0]        last_port_q, last_port_d;
  logic              any_q, any_d;

  logic [2:0]        op_sel;
  logic [NPORT-1:0]  req_mask;
  logic              req_any;
  logic [NPORT-1:0]  hit_vec;
  logic [1:0]        search_start;
  logic [1:0]        win;

  // Returns the first set bit of req, searching upward from start with
  // wrap-around. The caller only uses the result when req is non-zero.
  function automatic logic [1:0] pick(input logic [NPORT-1:0] req,
                                      input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

`ifdef PORT_ANY_RR_EN
  logic [1:0] rr_q, rr_d;
  assign search_start = rr_q + 2'd1;
`else
  assign search_start = 2'd0;
`endif

  // Resolve the selector of the pending operation into a port mask.
  // Reads take priority over writes, and an empty mask means NIL.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    op_sel   = bus.rd_req ? bus.rd_sel : bus.wr_sel;
    req_mask = '0;
    req_any  = 1'b0;
    if (op_sel == SEL_ANY) begin
      req_mask = '1;
      req_any  = 1'b1;
    end else if (op_sel == SEL_LAST) begin
      if (last_port_q[2]) req_mask[last_port_q[1:0]] = 1'b1;
    end else if (!op_sel[2]) begin
      req_mask[op_sel[1:0]] = 1'b1;
    end
  end

  // Completed handshakes in the current wait state and the single winner
  // among them.
  assign hit_vec = (state_q == WR_WAIT) ? (bus.out_ack & out_valid_q)
                                        : (bus.in_valid & in_ready_q);
  assign win     = pick(hit_vec, search_start);

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    last_port_d = last_port_q;
    any_d       = any_q;
`ifdef PORT_ANY_RR_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          if (req_mask == '0) begin
            rd_data_d = '0;
            rd_done_d = 1'b1;
            state_d   = DONE;
          end else begin
            in_ready_d = req_mask;
            any_d      = req_any;
            state_d    = RD_WAIT;
          end
        end else if (bus.wr_req) begin
          if (req_mask == '0) begin
            wr_done_d = 1'b1;
            state_d   = DONE;
          end else begin
            out_data_d  = bus.wr_data;
            out_valid_d = req_mask;
            any_d       = req_any;
            state_d     = WR_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (hit_vec != '0) begin
          // A handshake stands even if the request drops on the same cycle.
          if (state_q == RD_WAIT) begin
            rd_data_d = bus.in_data[int'(win)*DATA_W +: DATA_W];
            rd_done_d = 1'b1;
          end else begin
            wr_done_d = 1'b1;
          end
          if (any_q) begin
            last_port_d = {1'b1, win};
`ifdef PORT_ANY_RR_EN
            rr_d        = win;
`endif
          end
          in_ready_d  = '0;
          out_valid_d = '0;
          state_d     = DONE;
        end else if ((state_q == RD_WAIT) ? !bus.rd_req : !bus.wr_req) begin
          in_ready_d  = '0;
          out_valid_d = '0;
          state_d     = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. A synchronous reset aborts any transfer
  // without issuing a done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_data_q   <= '0;
      out_data_q  <= '0;
      in_ready_q  <= '0;
      out_valid_q <= '0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      last_port_q <= '0;
      any_q       <= 1'b0;
`ifdef PORT_ANY_RR_EN
      rr_q        <= 2'd3;
`endif
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
      last_port_q <= last_port_d;
      any_q       <= any_d;
`ifdef PORT_ANY_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.last_port = last_port_q;
  assign bus.stall     = (bus.rd_req | bus.wr_req) & ~(rd_done_q | wr_done_q);

endmodule

// File: tb/tb_port_io_sched.sv
// Directed self-checking bench for port_io_sched. A table of read
// transactions covers the selectors and ANY arbitration. Hand-written
// sequences cover writes, MOV ordering, request drop and reset mid-transfer.
module tb_port_io_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  port_io_sched_if #(.DATA_W(8)) bus ();

  port_io_sched #(.DATA_W(8), .NPORT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    int          dly;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [7:0]  exp_data;
    logic [3:0]  exp_rdy;
    int          exp_done;
    logic [2:0]  exp_last;
  } rd_vec_t;

  rd_vec_t vecs [9];

  // Read through the scheduler. in_valid = vld from cycle dly on. Cycle 0 is
  // the cycle rd_req is first presented.
  task automatic do_read(input logic [2:0] sel, input int dly, input logic [3:0] vld,
                         input logic [31:0] data, output logic [3:0] rdy_seen,
                         output int stall_cyc, output int done_cnt, output int done_cyc);
    rdy_seen = '0; stall_cyc = 0; done_cnt = 0; done_cyc = -1;
    bus.rd_req = 1'b1; bus.rd_sel = sel; bus.in_data = data;
    for (int c = 0; c <= dly + 4; c++) begin
      bus.in_valid = (c >= dly && done_cnt == 0) ? vld : 4'b0;
      #1;
      if (bus.stall) stall_cyc++;
      rdy_seen |= bus.in_ready;
      if (bus.rd_done) begin
        done_cnt++;
        done_cyc = c;
        bus.rd_req = 1'b0;
        bus.in_valid = 4'b0;
      end
      @(negedge clk);
    end
    bus.rd_req = 1'b0;
    bus.in_valid = 4'b0;
  endtask

  // Write through the scheduler. out_ack = ack_mask from cycle ack_dly on,
  // until the done pulse.
  task automatic do_write(input logic [2:0] sel, input logic [7:0] data, input int ack_dly,
                          input logic [3:0] ack_mask, output logic [3:0] vseen,
                          output int vcyc, output int done_cnt, output int done_cyc);
    vseen = '0; vcyc = 0; done_cnt = 0; done_cyc = -1;
    bus.wr_req = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
    for (int c = 0; c <= ack_dly + 4; c++) begin
      bus.out_ack = (c >= ack_dly && done_cnt == 0) ? ack_mask : 4'b0;
      #1;
      if (bus.out_valid != 4'b0) vcyc++;
      vseen |= bus.out_valid;
      if (bus.wr_done) begin
        done_cnt++;
        done_cyc = c;
        bus.wr_req = 1'b0;
        bus.out_ack = 4'b0;
      end
      @(negedge clk);
    end
    bus.wr_req = 1'b0;
    bus.out_ack = 4'b0;
  endtask

  initial begin
    logic [3:0] seen;
    int         cyc_a, cnt_a, cyc_b, cnt_b, rd_cyc, wr_cyc, early_valid;

    // Expected results. Cases 5 and 6 depend on the arbitration mode.
    vecs[0] = '{3'd5, 0, 4'b0000, 32'h0,        8'h00, 4'b0000, 1, 3'b000};
    vecs[1] = '{3'd2, 3, 4'b0100, 32'h115A2233, 8'h5A, 4'b0100, 4, 3'b000};
    vecs[2] = '{3'd6, 0, 4'b0000, 32'h0,        8'h00, 4'b0000, 1, 3'b000};
    vecs[3] = '{3'd3, 1, 4'b1111, 32'h807F7F7F, 8'h80, 4'b1000, 2, 3'b000};
    vecs[4] = '{3'd4, 1, 4'b1010, 32'hD4C3B2A1, 8'hB2, 4'b1111, 2, 3'b101};
`ifdef PORT_ANY_RR_EN
    vecs[5] = '{3'd4, 1, 4'b1010, 32'hD4C3B2A1, 8'hD4, 4'b1111, 2, 3'b111};
    vecs[6] = '{3'd5, 2, 4'b1111, 32'h44332211, 8'h44, 4'b1000, 3, 3'b111};
    vecs[7] = '{3'd7, 0, 4'b0000, 32'h0,        8'h00, 4'b0000, 1, 3'b111};
    vecs[8] = '{3'd0, 1, 4'b0001, 32'h000000FF, 8'hFF, 4'b0001, 2, 3'b111};
`else
    vecs[5] = '{3'd4, 1, 4'b1010, 32'hD4C3B2A1, 8'hB2, 4'b1111, 2, 3'b101};
    vecs[6] = '{3'd5, 2, 4'b1111, 32'h44332211, 8'h22, 4'b0010, 3, 3'b101};
    vecs[7] = '{3'd7, 0, 4'b0000, 32'h0,        8'h00, 4'b0000, 1, 3'b101};
    vecs[8] = '{3'd0, 1, 4'b0001, 32'h000000FF, 8'hFF, 4'b0001, 2, 3'b101};
`endif

    rst_n = 1'b0;
    bus.rd_req = 1'b0; bus.rd_sel = 3'd0; bus.wr_req = 1'b0; bus.wr_sel = 3'd0;
    bus.wr_data = 8'h0; bus.in_data = 32'h0; bus.in_valid = 4'b0; bus.out_ack = 4'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_data",   32'(bus.rd_data),   32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_dones",     32'({bus.rd_done, bus.wr_done}), 32'h0);
    check("rst_last_port", 32'(bus.last_port), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven reads.
    for (int i = 0; i < 9; i++) begin
      do_read(vecs[i].sel, vecs[i].dly, vecs[i].vld, vecs[i].data, seen, cyc_a, cnt_a, cyc_b);
      check($sformatf("rd%0d_data", i),      32'(bus.rd_data),   32'(vecs[i].exp_data));
      check($sformatf("rd%0d_ready", i),     32'(seen),          32'(vecs[i].exp_rdy));
      check($sformatf("rd%0d_done_cnt", i),  32'(cnt_a),         32'd1);
      check($sformatf("rd%0d_done_cyc", i),  32'(cyc_b),         32'(vecs[i].exp_done));
      check($sformatf("rd%0d_stall", i),     32'(cyc_a),         32'(vecs[i].exp_done));
      check($sformatf("rd%0d_last", i),      32'(bus.last_port), 32'(vecs[i].exp_last));
      check($sformatf("rd%0d_ready_off", i), 32'(bus.in_ready),  32'h0);
    end

    // ANY write, ack on port 0 at cycle 3.
    do_write(3'd4, 8'hC3, 3, 4'b0001, seen, cyc_a, cnt_a, cyc_b);
    check("wany_valid",     32'(seen),          32'hF);
    check("wany_vcyc",      32'(cyc_a),         32'd3);
    check("wany_done_cnt",  32'(cnt_a),         32'd1);
    check("wany_done_cyc",  32'(cyc_b),         32'd4);
    check("wany_out_data",  32'(bus.out_data),  32'hC3);
    check("wany_last",      32'(bus.last_port), 32'b100);
    check("wany_valid_off", 32'(bus.out_valid), 32'h0);

    // ANY write with simultaneous acks on ports 2 and 3: port 2 wins.
    do_write(3'd4, 8'h5E, 1, 4'b1100, seen, cyc_a, cnt_a, cyc_b);
    check("wany2_done_cyc", 32'(cyc_b),         32'd2);
    check("wany2_last",     32'(bus.last_port), 32'b110);
    check("wany2_out_data", 32'(bus.out_data),  32'h5E);

    // NIL write discards the payload.
    do_write(3'd6, 8'hEE, 0, 4'b0000, seen, cyc_a, cnt_a, cyc_b);
    check("wnil_valid",     32'(seen),          32'h0);
    check("wnil_done_cyc",  32'(cyc_b),         32'd1);
    check("wnil_out_data",  32'(bus.out_data),  32'h5E);

    // LAST write resolves to port 2.
    do_write(3'd5, 8'h01, 2, 4'b0100, seen, cyc_a, cnt_a, cyc_b);
    check("wlast_valid",    32'(seen),          32'b0100);
    check("wlast_done_cyc", 32'(cyc_b),         32'd3);
    check("wlast_out_data", 32'(bus.out_data),  32'h01);

    // MOV: read port 0 and write port 2 requested together.
    cnt_a = 0; cnt_b = 0; rd_cyc = -1; wr_cyc = -1; seen = '0; early_valid = 0;
    bus.rd_req = 1'b1; bus.rd_sel = 3'd0; bus.wr_req = 1'b1; bus.wr_sel = 3'd2;
    bus.wr_data = 8'h11; bus.in_data = 32'h00000077;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c >= 1 && cnt_a == 0) ? 4'b0001 : 4'b0000;
      bus.out_ack  = bus.out_valid & 4'b0100;
      #1;
      seen |= bus.out_valid;
      if (bus.out_valid != 4'b0 && cnt_a == 0) early_valid++;
      if (bus.rd_done) begin
        cnt_a++; rd_cyc = c;
        bus.rd_req = 1'b0; bus.in_valid = 4'b0; bus.wr_data = 8'h99;
      end
      if (bus.wr_done) begin
        cnt_b++; wr_cyc = c;
        bus.wr_req = 1'b0; bus.out_ack = 4'b0;
      end
      @(negedge clk);
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.out_ack = 4'b0; bus.in_valid = 4'b0;
    check("mov_rd_cnt",   32'(cnt_a),        32'd1);
    check("mov_wr_cnt",   32'(cnt_b),        32'd1);
    check("mov_rd_cyc",   32'(rd_cyc),       32'd2);
    check("mov_wr_cyc",   32'(wr_cyc),       32'd5);
    check("mov_early",    32'(early_valid),  32'd0);
    check("mov_valid",    32'(seen),         32'b0100);
    check("mov_rd_data",  32'(bus.rd_data),  32'h77);
    check("mov_out_data", 32'(bus.out_data), 32'h99);

    // Read request dropped in RD_WAIT with no handshake: abort, no done.
    bus.rd_req = 1'b1; bus.rd_sel = 3'd1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("drop_ready_on", 32'(bus.in_ready), 32'b0010);
    bus.rd_req = 1'b0;
    cnt_a = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (bus.rd_done) cnt_a++;
      if (c == 0) check("drop_ready_off", 32'(bus.in_ready), 32'h0);
    end
    check("drop_no_done", 32'(cnt_a), 32'd0);

    // Drop coinciding with a handshake: the transfer still completes.
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_sel = 3'd3; bus.in_data = 32'hAB000000;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.in_valid = 4'b1000;
    @(negedge clk);
    bus.in_valid = 4'b0;
    #1;
    check("drophs_done", 32'(bus.rd_done), 32'd1);
    check("drophs_data", 32'(bus.rd_data), 32'hAB);

    // Reset during WR_WAIT.
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 8'h3C;
    @(negedge clk);
    #1;
    check("rstw_valid_on", 32'(bus.out_valid), 32'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus.wr_req = 1'b0;
    #1;
    check("rstw_valid_off", 32'(bus.out_valid), 32'h0);
    check("rstw_last",      32'(bus.last_port), 32'h0);
    check("rstw_out_data",  32'(bus.out_data),  32'h0);
    cnt_b = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.wr_done) cnt_b++;
      @(negedge clk);
      #1;
    end
    check("rstw_no_done", 32'(cnt_b), 32'd0);
    @(negedge clk);

    // After reset LAST is NIL again, which shows that the FSM restarted from IDLE.
    do_read(3'd5, 0, 4'b1111, 32'hFFFFFFFF, seen, cyc_a, cnt_a, cyc_b);
    check("post_rst_last_ready", 32'(seen),        32'h0);
    check("post_rst_last_done",  32'(cyc_b),       32'd1);
    check("post_rst_last_data",  32'(bus.rd_data), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
